// File: rtl/div_share_arb.sv
// Round-robin share of one fixed-latency divider across N_REQ lanes; handshake->rsp_vld = DIV_LAT+2.
// No backpressure on results; define DIV_ZERO_GUARD_EN to zero results whose divisor was 0.
module div_share_arb #(
  parameter int N_REQ   = 2,
  parameter int DVD_W   = 24,
  parameter int DVS_W   = 16,
  parameter int Q_W     = 40,
  parameter int U_W     = 17,
  parameter int DIV_LAT = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [N_REQ-1:0]       req_vld,
  output logic [N_REQ-1:0]       req_rdy,
  input  logic [N_REQ*DVD_W-1:0] req_dvd,
  input  logic [N_REQ*DVS_W-1:0] req_dvs,
  input  logic [N_REQ-1:0]       req_tlast,
  input  logic [N_REQ*U_W-1:0]   req_tuser,
  output logic                   div_s_vld,
  output logic [DVD_W-1:0]       div_s_dvd,
  output logic [DVS_W-1:0]       div_s_dvs,
  input  logic                   div_m_vld,
  input  logic [Q_W-1:0]         div_m_data,
  output logic [N_REQ-1:0]       rsp_vld,
  output logic [Q_W-1:0]         rsp_data,
  output logic                   rsp_tlast,
  output logic [U_W-1:0]         rsp_tuser,
  output logic                   rsp_dz,
  output logic                   busy,
  output logic                   err_sync
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MSK_W = $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            tlast;
    logic [U_W-1:0]  tuser;
`ifdef DIV_ZERO_GUARD_EN
    logic            dz;
`endif
  } tag_t;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  scan;
  logic             gnt_any;
  logic [N_REQ-1:0] gnt;
  logic [DVS_W-1:0] sel_dvs;
  tag_t             tag_in;
  tag_t             tag_pipe [DIV_LAT+1];
  tag_t             tail;
  logic             tags_busy;
  logic [MSK_W-1:0] sync_mask;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = ID_W'((int'(ptr) + k) % N_REQ);
      if (rst_n && run && !gnt_any && req_vld[scan]) begin
        gnt_any = 1'b1;
        gnt_id  = scan;
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign req_rdy = gnt;
  assign sel_dvs = req_dvs[int'(gnt_id)*DVS_W +: DVS_W];

  always_comb begin
    tag_in       = '0;
    tag_in.vld   = gnt_any;
    tag_in.id    = gnt_id;
    tag_in.tlast = req_tlast[gnt_id];
    tag_in.tuser = req_tuser[int'(gnt_id)*U_W +: U_W];
`ifdef DIV_ZERO_GUARD_EN
    tag_in.dz    = (sel_dvs == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      div_s_vld <= 1'b0;
      div_s_dvd <= '0;
      div_s_dvs <= '0;
      for (int i = 0; i <= DIV_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      div_s_vld <= gnt_any;
      if (gnt_any) begin
        ptr       <= ID_W'((int'(gnt_id) + 1) % N_REQ);
        div_s_dvd <= req_dvd[int'(gnt_id)*DVD_W +: DVD_W];
        div_s_dvs <= sel_dvs;
      end
      tag_pipe[0] <= tag_in;
      for (int i = 1; i <= DIV_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tail = tag_pipe[DIV_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_vld   <= '0;
      rsp_data  <= '0;
      rsp_tlast <= 1'b0;
      rsp_tuser <= '0;
    end else begin
      rsp_vld <= '0;
      if (tail.vld) begin
        rsp_vld[tail.id] <= 1'b1;
        rsp_tlast        <= tail.tlast;
        rsp_tuser        <= tail.tuser;
`ifdef DIV_ZERO_GUARD_EN
        rsp_data         <= tail.dz ? '0 : div_m_data;
`else
        rsp_data         <= div_m_data;
`endif
      end
    end
  end

`ifdef DIV_ZERO_GUARD_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        rsp_dz <= 1'b0;
    else if (tail.vld) rsp_dz <= tail.dz;
  end
`else
  assign rsp_dz = 1'b0;
`endif

  // The divider is not reset with us: results of pre-reset issues may still emerge
  // for DIV_LAT cycles, so the sync check is blinded for that window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_mask <= MSK_W'(DIV_LAT);
      err_sync  <= 1'b0;
    end else begin
      if (sync_mask != '0) sync_mask <= sync_mask - 1'b1;
      if (sync_mask == '0 && tail.vld != div_m_vld) err_sync <= 1'b1;
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i <= DIV_LAT; i++) tags_busy = tags_busy | tag_pipe[i].vld;
  end

  assign busy = div_s_vld | tags_busy | (|rsp_vld);

endmodule

// File: tb/tb_div_share_arb.sv
// Directed bench for div_share_arb with a behavioural fixed-latency divider and result scoreboard.
module tb_div_share_arb;

  localparam int N_REQ   = 2;
  localparam int DVD_W   = 24;
  localparam int DVS_W   = 16;
  localparam int Q_W     = 40;
  localparam int U_W     = 17;
  localparam int DIV_LAT = 20;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   run;
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0]       req_rdy;
  logic [N_REQ*DVD_W-1:0] req_dvd;
  logic [N_REQ*DVS_W-1:0] req_dvs;
  logic [N_REQ-1:0]       req_tlast;
  logic [N_REQ*U_W-1:0]   req_tuser;
  logic                   div_s_vld;
  logic [DVD_W-1:0]       div_s_dvd;
  logic [DVS_W-1:0]       div_s_dvs;
  logic                   div_m_vld;
  logic [Q_W-1:0]         div_m_data;
  logic [N_REQ-1:0]       rsp_vld;
  logic [Q_W-1:0]         rsp_data;
  logic                   rsp_tlast;
  logic [U_W-1:0]         rsp_tuser;
  logic                   rsp_dz;
  logic                   busy;
  logic                   err_sync;

  div_share_arb #(
    .N_REQ(N_REQ), .DVD_W(DVD_W), .DVS_W(DVS_W), .Q_W(Q_W), .U_W(U_W), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_dvd(req_dvd), .req_dvs(req_dvs),
    .req_tlast(req_tlast), .req_tuser(req_tuser),
    .div_s_vld(div_s_vld), .div_s_dvd(div_s_dvd), .div_s_dvs(div_s_dvs),
    .div_m_vld(div_m_vld), .div_m_data(div_m_data),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_tlast(rsp_tlast), .rsp_tuser(rsp_tuser),
    .rsp_dz(rsp_dz), .busy(busy), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Fixed-point quotient: dividend scaled by 2^16; divide by zero yields all ones.
  function automatic logic [Q_W-1:0] div_q(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
    logic [Q_W-1:0] num;
    num = {a, {(Q_W-DVD_W){1'b0}}};
    if (b == '0) return '1;
    return num / Q_W'(b);
  endfunction

  // Behavioural divider, never reset; drop_arm suppresses its valid.
  logic [DIV_LAT-1:0] mdl_v = '0;
  logic [Q_W-1:0]     mdl_d [DIV_LAT];
  logic               drop_arm;

  always @(posedge clk) begin
    mdl_v    <= {mdl_v[DIV_LAT-2:0], div_s_vld};
    mdl_d[0] <= div_q(div_s_dvd, div_s_dvs);
    for (int i = 1; i < DIV_LAT; i++) mdl_d[i] <= mdl_d[i-1];
  end

  assign div_m_vld  = mdl_v[DIV_LAT-1] & ~drop_arm;
  assign div_m_data = mdl_d[DIV_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    int             lane;
    logic [Q_W-1:0] data;
    logic           tlast;
    logic [U_W-1:0] tuser;
    logic           dz;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  exp_t pe;
  exp_t ce;

  always @(negedge clk) begin
    if (|rsp_vld) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
      end else begin
        ce = sb.pop_front();
        chk("rsp_lane",    64'(rsp_vld),   64'(1) << ce.lane);
        chk("rsp_data",    64'(rsp_data),  64'(ce.data));
        chk("rsp_tlast",   64'(rsp_tlast), 64'(ce.tlast));
        chk("rsp_tuser",   64'(rsp_tuser), 64'(ce.tuser));
        chk("rsp_dz",      64'(rsp_dz),    64'(ce.dz));
        chk("rsp_latency", 64'(cyc - ce.cyc), 64'(DIV_LAT + 2));
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (req_vld[i] && req_rdy[i]) begin
        pe.lane  = i;
        pe.tlast = req_tlast[i];
        pe.tuser = req_tuser[i*U_W +: U_W];
        pe.cyc   = cyc;
`ifdef DIV_ZERO_GUARD_EN
        pe.dz    = (req_dvs[i*DVS_W +: DVS_W] == '0);
        pe.data  = pe.dz ? '0 : div_q(req_dvd[i*DVD_W +: DVD_W], req_dvs[i*DVS_W +: DVS_W]);
`else
        pe.dz    = 1'b0;
        pe.data  = div_q(req_dvd[i*DVD_W +: DVD_W], req_dvs[i*DVS_W +: DVS_W]);
`endif
        sb.push_back(pe);
      end
    end
  end

  task automatic set_lane(input int l, input int s);
    req_dvd[l*DVD_W +: DVD_W] = DVD_W'(1000 + 250*l + 37*s);
    req_dvs[l*DVS_W +: DVS_W] = DVS_W'(3 + s + 5*l);
    req_tlast[l]              = (s % 4 == 3);
    req_tuser[l*U_W +: U_W]   = U_W'(l*256 + s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [N_REQ-1:0] g;
    int nxt, s0, s1, base;

    rst_n = 1'b0; run = 1'b1; req_vld = '1; drop_arm = 1'b0;
    req_dvd = '0; req_dvs = '0; req_tlast = '0; req_tuser = '0;
    set_lane(0, 0); set_lane(1, 0);
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_rdy",   64'(req_rdy),   64'd0);
    chk("rst_div_s_vld", 64'(div_s_vld), 64'd0);
    chk("rst_rsp_vld",   64'(rsp_vld),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_err_sync",  64'(err_sync),  64'd0);
    chk("rst_rsp_data",  64'(rsp_data),  64'd0);
    chk("rst_rsp_dz",    64'(rsp_dz),    64'd0);
    step();
    req_vld = '0; rst_n = 1'b1;

    // Single lane-0 division 1280/10.
    step();
    req_dvd[0 +: DVD_W] = DVD_W'(1280);
    req_dvs[0 +: DVS_W] = DVS_W'(10);
    req_tlast[0] = 1'b1;
    req_tuser[0 +: U_W] = 17'h1ABCD;
    req_vld = 2'b01;
    @(negedge clk);
    chk("t1_rdy", 64'(req_rdy), 64'b01);
    step();
    req_vld = '0;
    drain(DIV_LAT + 10, "t1_drain");

    // Both lanes contend; pointer now sits at lane 1 after lane 0 was served.
    base = n_rsp; s0 = 1; s1 = 1; nxt = 1;
    set_lane(0, s0); set_lane(1, s1);
    req_vld = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = req_rdy;
      chk("t2_gnt", 64'(g), 64'(1) << nxt);
      nxt = 1 - nxt;
      step();
      if (g[0]) begin s0++; set_lane(0, s0); end
      if (g[1]) begin s1++; set_lane(1, s1); end
    end
    req_vld = '0;
    drain(DIV_LAT + 20, "t2_drain");
    chk("t2_count", 64'(n_rsp - base), 64'd8);

    // Three in flight, then run drops while lane 0 keeps requesting.
    set_lane(0, 10);
    req_vld = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_gnt", 64'(req_rdy), 64'b01);
      step();
      set_lane(0, 11 + i);
    end
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_norun", 64'(req_rdy), 64'd0);
      chk("t3_busy",  64'(busy),    64'd1);
      step();
    end
    req_vld = '0; run = 1'b1;
    drain(DIV_LAT + 10, "t3_drain");
    chk("t3_busy_low", 64'(busy),    64'd0);
    chk("t3_rsp_idle", 64'(rsp_vld), 64'd0);

    // Divider loses one valid.
    chk("t4_err_pre", 64'(err_sync), 64'd0);
    drop_arm = 1'b1;
    set_lane(0, 20);
    req_vld = 2'b01;
    @(negedge clk);
    chk("t4_rdy", 64'(req_rdy), 64'b01);
    step();
    req_vld = '0;
    drain(DIV_LAT + 10, "t4_drain");
    drop_arm = 1'b0;
    chk("t4_err", 64'(err_sync), 64'd1);
    repeat (10) step();
    chk("t4_err_sticky", 64'(err_sync), 64'd1);

    // Zero divisor on lane 1.
    set_lane(1, 30);
    req_dvs[DVS_W +: DVS_W] = '0;
    req_vld = 2'b10;
    @(negedge clk);
    chk("t5_rdy", 64'(req_rdy), 64'b10);
    step();
    req_vld = '0;
    drain(DIV_LAT + 10, "t5_drain");

    // Reset with five in flight; pointer left at lane 1 beforehand.
    set_lane(0, 40);
    req_vld = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_gnt", 64'(req_rdy), 64'b01);
      step();
      set_lane(0, 41 + i);
    end
    rst_n = 1'b0; req_vld = '0;
    sb.delete();
    base = n_rsp;
    step();
    rst_n = 1'b1;
    chk("t6_err_clr", 64'(err_sync), 64'd0);
    repeat (DIV_LAT + 8) step();
    chk("t6_no_rsp", 64'(n_rsp - base), 64'd0);
    chk("t6_err",    64'(err_sync),     64'd0);
    set_lane(0, 50); set_lane(1, 50);
    req_vld = 2'b11;
    @(negedge clk);
    chk("t6_ptr0", 64'(req_rdy), 64'b01);
    step();
    req_vld = '0;
    drain(DIV_LAT + 10, "t6_drain");
    chk("t6_err_end", 64'(err_sync), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
